lfsr_rng: RTL

LFSR_RNG -- requirements
Module: lfsr_rng

---
 rtl/lfsr_rng.sv | 110 +++++++++++
 1 files changed

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random word generator with a valid/ready output handshake,
// runtime reseeding with zero-seed substitution, and all-zero lockup recovery.
module lfsr_rng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             seed_zero,
  output logic             lockup
);

  localparam int               CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {FILL, VALID} fsm_t;

  fsm_t             fsm, fsm_n;
  logic [WIDTH-1:0] lfsr, lfsr_n, lfsr_adv;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [OUT_W-1:0] data_n;
  logic             seed_zero_n, lockup_n;

  function automatic logic [WIDTH-1:0] shift_lfsr(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign lfsr_adv  = shift_lfsr(lfsr);
  assign cnt_inc   = cnt + 1'b1;
  assign rnd_valid = (fsm == VALID);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr      <= SEED;
      cnt       <= '0;
      fsm       <= FILL;
      rnd_data  <= '0;
      seed_zero <= 1'b0;
      lockup    <= 1'b0;
    end else begin
      lfsr      <= lfsr_n;
      cnt       <= cnt_n;
      fsm       <= fsm_n;
      rnd_data  <= data_n;
      seed_zero <= seed_zero_n;
      lockup    <= lockup_n;
    end
  end

  // Priority: reseed, then zero-state recovery, then normal fill/handshake.
  always_comb begin
    lfsr_n      = lfsr;
    cnt_n       = cnt;
    fsm_n       = fsm;
    data_n      = rnd_data;
    seed_zero_n = 1'b0;
    lockup_n    = 1'b0;
    if (seed_load) begin
      seed_zero_n = (seed_in == '0);
      lfsr_n      = (seed_in == '0) ? SEED : seed_in;
      cnt_n       = '0;
      fsm_n       = FILL;
    end else if (lfsr == '0) begin
      lfsr_n   = SEED;
      cnt_n    = '0;
      fsm_n    = FILL;
      lockup_n = 1'b1;
    end else begin
      case (fsm)
        FILL: begin
          if (en) begin
            lfsr_n = lfsr_adv;
            cnt_n  = cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              fsm_n  = VALID;
              data_n = lfsr_adv[OUT_W-1:0];
            end
          end
        end
        VALID: begin
          if (rnd_ready) begin
            if (en) begin
              lfsr_n = lfsr_adv;
              cnt_n  = CNT_ONE;
              if (OUT_W == 1) begin
                data_n = lfsr_adv[OUT_W-1:0];
              end else begin
                fsm_n = FILL;
              end
            end else begin
              cnt_n = '0;
              fsm_n = FILL;
            end
          end
        end
        default: fsm_n = FILL;
      endcase
    end
  end

endmodule
